elevator_motion_ctrl: RTL and testbench

Downstream consumer of the SOS handler's `sos_mode` flag. It holds pending floor calls, moves the car one floor at a time with a fixed per-floor travel time, and opens the door at served floors. While `sos_mode` is high it forces the car to halt with the door closed. It drives the floor indicator and motor/door status outputs of the elevator top level.

---
 rtl/elevator_pkg.sv | 17 +
 rtl/call_register.sv | 58 +++++
 rtl/elevator_motion_ctrl.sv | 162 ++++++++++++++++
 tb/tb_elevator_motion_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator motion controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2,
        SOS    = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned DEFAULT_NUM_FLOORS = 8;
    localparam int unsigned DEFAULT_FLOOR_W    = 3;

endpackage

// File: rtl/call_register.sv
// Pending-call bitmap with set/clear ports and above/below reductions
// relative to the car's current floor.
module call_register
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int unsigned FLOOR_W    = DEFAULT_FLOOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_all,
    input  logic                  set_en,
    input  logic [FLOOR_W-1:0]    set_floor,
    input  logic                  clr_en,
    input  logic [FLOOR_W-1:0]    clr_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  any_above,
    output logic                  any_below
);

    logic [NUM_FLOORS-1:0] pending_next;

    // Next bitmap: a clear for the same floor beats a set (the floor is being served).
    always_comb begin
        pending_next = pending;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (clr_en && clr_floor == FLOOR_W'(i)) begin
                pending_next[i] = 1'b0;
            end else if (set_en && set_floor == FLOOR_W'(i)) begin
                pending_next[i] = 1'b1;
            end
        end
        if (clear_all) begin
            pending_next = '0;
        end
    end

    // Bitmap register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Any call strictly above / strictly below the current floor.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && FLOOR_W'(i) > current_floor) any_above = 1'b1;
            if (pending[i] && FLOOR_W'(i) < current_floor) any_below = 1'b1;
        end
    end

endmodule

// File: rtl/elevator_motion_ctrl.sv
// Elevator car motion FSM: serves pending calls one floor at a time,
// opens the door at served floors, and halts while sos_mode is high.
module elevator_motion_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = DEFAULT_NUM_FLOORS,
    parameter int unsigned FLOOR_W       = DEFAULT_FLOOR_W,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sos_mode,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open,
    output logic                  halted,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);

    state_t               state;
    logic [TW-1:0]        travel_cnt;
    logic [DW-1:0]        door_cnt;
    logic                 any_above;
    logic                 any_below;
    logic                 call_ok;
    logic                 door_restart;
    logic                 travel_done;
    logic                 at_top;
    logic                 at_bottom;
    logic [FLOOR_W-1:0]   next_floor;
    logic                 next_pending;
    logic                 clr_en;
    logic [FLOOR_W-1:0]   clr_floor;
    logic                 clear_all;

    // Call qualification, door restart and next-floor lookahead.
    always_comb begin
        call_ok      = call_valid && (32'(call_floor) < NUM_FLOORS) && (state != SOS) && !sos_mode;
        door_restart = call_ok && (state == DOOR) && (call_floor == current_floor);
        travel_done  = (travel_cnt == TW'(TRAVEL_CYCLES - 1));
        at_top       = (current_floor == FLOOR_W'(NUM_FLOORS - 1));
        at_bottom    = (current_floor == '0);
        next_floor   = current_floor;
        if (dir_up == DIR_UP && !at_top) begin
            next_floor = current_floor + 1'b1;
        end else if (dir_up == DIR_DOWN && !at_bottom) begin
            next_floor = current_floor - 1'b1;
        end
        next_pending = pending[next_floor];
        clear_all    = sos_mode || (state == SOS);
        clr_en       = 1'b0;
        clr_floor    = current_floor;
        if (state == IDLE && pending[current_floor]) begin
            clr_en = 1'b1;
        end else if (state == MOVING && travel_done && next_pending) begin
            clr_en    = 1'b1;
            clr_floor = next_floor;
        end
    end

    call_register #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_calls (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_all     (clear_all),
        .set_en        (call_ok && !door_restart),
        .set_floor     (call_floor),
        .clr_en        (clr_en),
        .clr_floor     (clr_floor),
        .current_floor (current_floor),
        .pending       (pending),
        .any_above     (any_above),
        .any_below     (any_below)
    );

    // Main FSM with registered outputs and both counters; sos_mode overrides all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            current_floor <= '0;
            moving        <= 1'b0;
            dir_up        <= DIR_UP;
            door_open     <= 1'b0;
            halted        <= 1'b0;
            travel_cnt    <= '0;
            door_cnt      <= '0;
        end else if (sos_mode) begin
            state      <= SOS;
            moving     <= 1'b0;
            door_open  <= 1'b0;
            halted     <= 1'b1;
            travel_cnt <= '0;
            door_cnt   <= '0;
        end else begin
            case (state)
                SOS: begin
                    state  <= IDLE;
                    halted <= 1'b0;
                end
                IDLE: begin
                    if (pending[current_floor]) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        door_cnt  <= '0;
                    end else if ((dir_up == DIR_UP && any_above) || (dir_up == DIR_DOWN && any_below)) begin
                        state      <= MOVING;
                        moving     <= 1'b1;
                        travel_cnt <= '0;
                    end else if (any_above || any_below) begin
                        dir_up     <= (dir_up == DIR_UP) ? DIR_DOWN : DIR_UP;
                        state      <= MOVING;
                        moving     <= 1'b1;
                        travel_cnt <= '0;
                    end
                end
                MOVING: begin
                    if (travel_done) begin
                        travel_cnt    <= '0;
                        current_floor <= next_floor;
                        // next_floor's bit is clear in the else branches, so the
                        // current-floor reductions equal "beyond the new floor".
                        if (next_pending) begin
                            state     <= DOOR;
                            moving    <= 1'b0;
                            door_open <= 1'b1;
                            door_cnt  <= '0;
                        end else if ((dir_up == DIR_UP) ? any_above : any_below) begin
                            state <= MOVING;
                        end else begin
                            state  <= IDLE;
                            moving <= 1'b0;
                        end
                    end else begin
                        travel_cnt <= travel_cnt + 1'b1;
                    end
                end
                DOOR: begin
                    if (door_restart) begin
                        door_cnt <= '0;
                    end else if (door_cnt == DW'(DOOR_CYCLES - 1)) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                        door_cnt  <= '0;
                    end else begin
                        door_cnt <= door_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed, table-driven bench for elevator_motion_ctrl.
module tb_elevator_motion_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sos_mode;
    logic       call_valid;
    logic [2:0] call_floor;
    logic [2:0] current_floor;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic       halted;
    logic [7:0] pending;

    logic       call_valid6;
    logic [2:0] call_floor6;
    logic [2:0] current_floor6;
    logic       moving6;
    logic       dir_up6;
    logic       door_open6;
    logic       halted6;
    logic [5:0] pending6;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] floor;
        int         exp_edges;
        logic       exp_dir;
        logic [7:0] exp_pend;
    } vec_t;

    vec_t vecs[5];

    elevator_motion_ctrl #(
        .NUM_FLOORS    (8),
        .FLOOR_W       (3),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sos_mode      (sos_mode),
        .call_valid    (call_valid),
        .call_floor    (call_floor),
        .current_floor (current_floor),
        .moving        (moving),
        .dir_up        (dir_up),
        .door_open     (door_open),
        .halted        (halted),
        .pending       (pending)
    );

    elevator_motion_ctrl #(
        .NUM_FLOORS    (6),
        .FLOOR_W       (3),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6)
    ) dut6 (
        .clk           (clk),
        .rst_n         (rst_n),
        .sos_mode      (1'b0),
        .call_valid    (call_valid6),
        .call_floor    (call_floor6),
        .current_floor (current_floor6),
        .moving        (moving6),
        .dir_up        (dir_up6),
        .door_open     (door_open6),
        .halted        (halted6),
        .pending       (pending6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents a one-cycle call; returns after the sampling edge.
    task automatic apply_call(input logic [2:0] f);
        @(negedge clk);
        call_valid = 1'b1;
        call_floor = f;
        @(negedge clk);
        call_valid = 1'b0;
    endtask

    // n counts edges since (and including) the call edge.
    task automatic wait_door_open(input int start, output int n);
        n = start;
        while (!door_open && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!door_open) check("door_open_timeout", 32'(door_open), 32'd1);
    endtask

    task automatic wait_door_close(output int len);
        len = 0;
        while (door_open && len < 50) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_floor(input logic [2:0] f);
        int n;
        n = 0;
        while (current_floor != f && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (current_floor != f) check("wait_floor_timeout", 32'(current_floor), 32'(f));
    endtask

    initial begin
        int n;
        int len;

        vecs[0] = '{3'd3, 14, 1'b1, 8'h08};
        vecs[1] = '{3'd3,  2, 1'b1, 8'h08};
        vecs[2] = '{3'd7, 18, 1'b1, 8'h80};
        vecs[3] = '{3'd6,  6, 1'b0, 8'h40};
        vecs[4] = '{3'd0, 26, 1'b0, 8'h01};

        rst_n       = 1'b0;
        sos_mode    = 1'b0;
        call_valid  = 1'b0;
        call_floor  = '0;
        call_valid6 = 1'b0;
        call_floor6 = '0;
        #12;
        check("rst_floor",   32'(current_floor), 32'd0);
        check("rst_moving",  32'(moving),        32'd0);
        check("rst_dir_up",  32'(dir_up),        32'd1);
        check("rst_door",    32'(door_open),     32'd0);
        check("rst_halted",  32'(halted),        32'd0);
        check("rst_pending", 32'(pending),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-call scenarios chained from floor 0.
        for (int i = 0; i < 5; i++) begin
            apply_call(vecs[i].floor);
            check($sformatf("v%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pend));
            wait_door_open(1, n);
            check($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].exp_edges));
            check($sformatf("v%0d_floor", i), 32'(current_floor), 32'(vecs[i].floor));
            check($sformatf("v%0d_dir", i), 32'(dir_up), 32'(vecs[i].exp_dir));
            wait_door_close(len);
            check($sformatf("v%0d_door_len", i), 32'(len), 32'd6);
            check($sformatf("v%0d_idle", i), 32'({moving, pending}), 32'd0);
        end

        // Same-floor call during DOOR restarts the door timer.
        apply_call(3'd0);
        wait_door_open(1, n);
        check("same_floor_latency", 32'(n), 32'd2);
        @(negedge clk);
        @(negedge clk);
        call_valid = 1'b1;
        call_floor = 3'd0;
        @(negedge clk);
        call_valid = 1'b0;
        check("door_restart_not_stored", 32'(pending), 32'd0);
        wait_door_close(len);
        check("door_extend_len", 32'(len), 32'd6);

        // SOS pulse mid-travel between floors 1 and 2.
        apply_call(3'd3);
        wait_floor(3'd1);
        @(negedge clk);
        @(negedge clk);
        sos_mode   = 1'b1;
        call_valid = 1'b1;
        call_floor = 3'd5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            call_valid = 1'b0;
            check($sformatf("sos%0d_halted", c),  32'(halted),        32'd1);
            check($sformatf("sos%0d_moving", c),  32'(moving),        32'd0);
            check($sformatf("sos%0d_pending", c), 32'(pending),       32'd0);
            check($sformatf("sos%0d_floor", c),   32'(current_floor), 32'd1);
            if (c == 0) begin
                call_valid = 1'b1;
                call_floor = 3'd6;
            end
        end
        sos_mode = 1'b0;
        @(negedge clk);
        check("sos_rel_halted",  32'(halted),                      32'd0);
        check("sos_rel_outs",    32'({moving, door_open, pending}), 32'd0);
        check("sos_rel_floor",   32'(current_floor),               32'd1);
        @(negedge clk);
        check("sos_rel_idle",    32'({moving, door_open}),         32'd0);

        // Moving up past floor 2 with calls for 5 and 1.
        apply_call(3'd5);
        wait_floor(3'd2);
        apply_call(3'd1);
        check("two_calls_pending", 32'(pending), 32'h22);
        check("two_calls_moving",  32'(moving),  32'd1);
        check("two_calls_dir",     32'(dir_up),  32'd1);
        wait_door_open(0, n);
        check("serve5_floor",   32'(current_floor), 32'd5);
        check("serve5_pending", 32'(pending),       32'h02);
        wait_door_close(len);
        wait_door_open(0, n);
        check("serve1_floor", 32'(current_floor), 32'd1);
        check("serve1_dir",   32'(dir_up),        32'd0);
        wait_door_close(len);
        check("serve1_pending", 32'(pending), 32'd0);

        // Asynchronous reset while the door is open at floor 4.
        apply_call(3'd4);
        wait_door_open(0, n);
        check("pre_rst_floor", 32'(current_floor), 32'd4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_floor",   32'(current_floor), 32'd0);
        check("arst_door",    32'(door_open),     32'd0);
        check("arst_dir",     32'(dir_up),        32'd1);
        check("arst_others",  32'({moving, halted, pending}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'({moving, door_open}), 32'd0);

        // Out-of-range call on the six-floor instance.
        @(negedge clk);
        call_valid6 = 1'b1;
        call_floor6 = 3'd7;
        @(negedge clk);
        call_valid6 = 1'b0;
        check("nf6_oor_pending", 32'(pending6), 32'd0);
        repeat (3) @(negedge clk);
        check("nf6_oor_idle", 32'({moving6, door_open6}), 32'd0);
        check("nf6_oor_floor", 32'(current_floor6), 32'd0);
        call_valid6 = 1'b1;
        call_floor6 = 3'd5;
        @(negedge clk);
        call_valid6 = 1'b0;
        check("nf6_top_pending", 32'(pending6), 32'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
